// File: rtl/nice_gemm_pkg.sv
// nice_gemm_pkg: shared opcodes, status codes, FSM states and descriptor type for the GEMM NICE issuer
package nice_gemm_pkg;
   localparam logic [6:0] OPCODE   = 7'b0101011;
   localparam logic [6:0] F7_CFG0  = 7'b0000001;
   localparam logic [6:0] F7_CFG1  = 7'b0000010;
   localparam logic [6:0] F7_CFG2  = 7'b0000100;
   localparam logic [6:0] F7_CFG3  = 7'b0001000;
   localparam logic [6:0] F7_CFG4  = 7'b0010000;
   localparam logic [6:0] F7_CFG5  = 7'b0100000;
   localparam logic [6:0] F7_START = 7'b1000000;
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_CFG_REJ = 2'b01;
   localparam logic [1:0] ST_RSP_ERR = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;
   typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_WAIT, S_FIN} state_t;
   typedef struct packed {
      logic [31:0] lhs_cols;
      logic [31:0] lhs_rows;
      logic [31:0] rhs_cols;
      logic [31:0] bias_addr;
      logic [31:0] lhs_addr;
      logic [31:0] rhs_addr;
      logic [31:0] lhs_offset;
      logic [31:0] dst_offset;
      logic [31:0] act_min;
      logic [31:0] act_max;
      logic [31:0] dst_multi_addr;
      logic [31:0] dst_shifts_addr;
      logic [31:0] dst_addr;
   } job_t;
   function automatic logic [31:0] instr_word(input logic [6:0] funct7, input logic [6:0] opc);
      return {funct7, 18'b0, opc};
   endfunction
endpackage

// File: rtl/nice_cfg_mux.sv
// nice_cfg_mux: picks funct7 and operands for instruction step idx (0..5 config, 6 start)
module nice_cfg_mux
   import nice_gemm_pkg::*;
(
   input  job_t        job,
   input  logic [2:0]  idx,
   output logic [6:0]  funct7,
   output logic [31:0] rs1,
   output logic [31:0] rs2
);
   // any idx beyond the config range falls through to the start command
   always_comb begin
      funct7 = F7_START;
      rs1    = job.dst_addr;
      rs2    = '0;
      case (idx)
         3'd0: begin funct7 = F7_CFG0; rs1 = job.lhs_cols;       rs2 = job.lhs_rows;        end
         3'd1: begin funct7 = F7_CFG1; rs1 = job.rhs_cols;       rs2 = job.bias_addr;       end
         3'd2: begin funct7 = F7_CFG2; rs1 = job.lhs_addr;       rs2 = job.rhs_addr;        end
         3'd3: begin funct7 = F7_CFG3; rs1 = job.lhs_offset;     rs2 = job.dst_offset;      end
         3'd4: begin funct7 = F7_CFG4; rs1 = job.act_min;        rs2 = job.act_max;         end
         3'd5: begin funct7 = F7_CFG5; rs1 = job.dst_multi_addr; rs2 = job.dst_shifts_addr; end
         default: ;
      endcase
   end
endmodule

// File: rtl/nice_gemm_issuer.sv
// nice_gemm_issuer: issues six config instructions and a start over NICE, then waits for completion
module nice_gemm_issuer #(
   parameter logic [6:0] OPCODE      = nice_gemm_pkg::OPCODE,
   parameter int         TIMEOUT_CYC = 65535,
   parameter int         CNT_W       = 16
) (
   input  logic        nice_clk,
   input  logic        nice_rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_lhs_cols,
   input  logic [31:0] job_lhs_rows,
   input  logic [31:0] job_rhs_cols,
   input  logic [31:0] job_bias_addr,
   input  logic [31:0] job_lhs_addr,
   input  logic [31:0] job_rhs_addr,
   input  logic [31:0] job_lhs_offset,
   input  logic [31:0] job_dst_offset,
   input  logic [31:0] job_act_min,
   input  logic [31:0] job_act_max,
   input  logic [31:0] job_dst_multi_addr,
   input  logic [31:0] job_dst_shifts_addr,
   input  logic [31:0] job_dst_addr,
   output logic        nice_req_valid,
   input  logic        nice_req_ready,
   output logic [31:0] nice_req_instr,
   output logic [31:0] nice_req_rs1,
   output logic [31:0] nice_req_rs2,
   input  logic        nice_rsp_1cyc_type,
   input  logic [31:0] nice_rsp_1cyc_dat_1,
   input  logic        nice_rsp_1cyc_err,
   input  logic        nice_rsp_multicyc_valid,
   output logic        nice_rsp_multicyc_ready,
   input  logic        nice_rsp_multicyc_err,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status
);
   import nice_gemm_pkg::*;
   state_t            state;
   job_t              job;
   logic [2:0]        idx;
   logic [CNT_W-1:0]  cnt;
   logic [6:0]        funct7;
   logic [31:0]       rs1;
   logic [31:0]       rs2;
   logic              cfg_bad;
   logic              unused_dat;
   assign unused_dat     = ^nice_rsp_1cyc_dat_1[31:1];
   assign cfg_bad        = nice_rsp_1cyc_err | ~nice_rsp_1cyc_type | ~nice_rsp_1cyc_dat_1[0];
   assign nice_req_instr = nice_req_valid ? instr_word(funct7, OPCODE) : '0;
   assign nice_req_rs1   = nice_req_valid ? rs1 : '0;
   assign nice_req_rs2   = nice_req_valid ? rs2 : '0;
   nice_cfg_mux u_mux (
      .job    (job),
      .idx    (idx),
      .funct7 (funct7),
      .rs1    (rs1),
      .rs2    (rs2)
   );
   // capture the descriptor on acceptance; it needs no reset since it is only read after a capture
   always_ff @(posedge nice_clk) begin
      if (state == S_IDLE && job_valid)
         job <= '{job_lhs_cols, job_lhs_rows, job_rhs_cols, job_bias_addr, job_lhs_addr, job_rhs_addr,
                  job_lhs_offset, job_dst_offset, job_act_min, job_act_max, job_dst_multi_addr,
                  job_dst_shifts_addr, job_dst_addr};
   end
   // issue FSM with registered handshake/status outputs and the completion timeout counter
   always_ff @(posedge nice_clk) begin
      if (nice_rst) begin
         state                   <= S_IDLE;
         idx                     <= '0;
         cnt                     <= '0;
         job_ready               <= 1'b1;
         nice_req_valid          <= 1'b0;
         nice_rsp_multicyc_ready <= 1'b0;
         busy                    <= 1'b0;
         done                    <= 1'b0;
         status                  <= ST_OK;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (job_valid) begin
               idx            <= '0;
               job_ready      <= 1'b0;
               busy           <= 1'b1;
               nice_req_valid <= 1'b1;
               state          <= S_CFG;
            end
            S_CFG: if (nice_req_ready) begin
               if (cfg_bad) begin
                  status         <= ST_CFG_REJ;
                  nice_req_valid <= 1'b0;
                  done           <= 1'b1;
                  state          <= S_FIN;
               end else begin
                  idx <= idx + 3'd1;
                  if (idx == 3'd5) state <= S_START;
               end
            end
            S_START: if (nice_req_ready) begin
               cnt                     <= '0;
               nice_req_valid          <= 1'b0;
               nice_rsp_multicyc_ready <= 1'b1;
               state                   <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (nice_rsp_multicyc_valid || (TIMEOUT_CYC != 0 && cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
                  status                  <= nice_rsp_multicyc_valid ? (nice_rsp_multicyc_err ? ST_RSP_ERR : ST_OK) : ST_TIMEOUT;
                  nice_rsp_multicyc_ready <= 1'b0;
                  done                    <= 1'b1;
                  state                   <= S_FIN;
               end
            end
            S_FIN: begin
               busy      <= 1'b0;
               job_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/nice_gemm_issuer.md
Name: nice_gemm_issuer

Overview:
Initiator (core-side) end of the NICE custom-instruction channel for the GEMM accelerator. It accepts one GEMM job descriptor and issues the six config instructions plus the start instruction over the NICE request channel. It then waits for the multi-cycle completion response and reports done/status. Used by the DMA/sequencer subsystem and in standalone accelerator benches in place of the CPU.

Parameters:
- OPCODE, 7'b0101011, custom-1 major opcode placed in instr[6:0]
- TIMEOUT_CYC, 65535, max cycles in WAIT_RSP before timeout error; 0 disables timeout
- CNT_W, 16, width of the timeout counter

Ports:
- nice_clk  in  1  sole clock
- nice_rst  in  1  reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  descriptor accepted when high with job_valid
- job_lhs_cols, job_lhs_rows, job_rhs_cols, job_bias_addr, job_lhs_addr, job_rhs_addr, job_lhs_offset, job_dst_offset, job_act_min, job_act_max, job_dst_multi_addr, job_dst_shifts_addr, job_dst_addr  in  32 each  descriptor fields
- nice_req_valid  out  1  request valid
- nice_req_ready  in  1  accelerator ready
- nice_req_instr  out  32  instruction word
- nice_req_rs1  out  32  operand 1
- nice_req_rs2  out  32  operand 2
- nice_rsp_1cyc_type  in  1  same-cycle response flag
- nice_rsp_1cyc_dat_1  in  32  config ack (bit0 = 1 means accepted)
- nice_rsp_1cyc_err  in  1  config error
- nice_rsp_multicyc_valid  in  1  completion valid
- nice_rsp_multicyc_ready  out  1  completion ready
- nice_rsp_multicyc_err  in  1  completion error
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- status  out  2  00 ok, 01 config rejected, 10 multicyc_err, 11 timeout; valid with done, held until next done

Behaviour:
- Clocking/reset: one clock nice_clk; reset nice_rst is synchronous, active-high.
- Reset values: state IDLE; job_ready=1; nice_req_valid=0; nice_rsp_multicyc_ready=0; busy=0; done=0; status=00; instr/rs1/rs2=0.
- Reset mid-operation: on the first edge with nice_rst=1, nice_req_valid drops and the FSM returns to IDLE. No done pulse is generated.
- Instruction word: instr[31:25]=funct7, instr[24:7]=0, instr[6:0]=OPCODE.
- Config sequence, idx 0..5:
  - idx 0: funct7 0000001, rs1=lhs_cols, rs2=lhs_rows
  - idx 1: funct7 0000010, rs1=rhs_cols, rs2=bias_addr
  - idx 2: funct7 0000100, rs1=lhs_addr, rs2=rhs_addr
  - idx 3: funct7 0001000, rs1=lhs_offset, rs2=dst_offset
  - idx 4: funct7 0010000, rs1=act_min, rs2=act_max
  - idx 5: funct7 0100000, rs1=dst_multi_addr, rs2=dst_shifts_addr
- Start instruction: funct7 1000000, rs1=dst_addr, rs2=0.
- FSM:
  - IDLE: job_ready=1. On job_valid&job_ready, register all 13 fields, set idx=0, go to CFG. Accept occurs the cycle after done at the earliest.
  - CFG: nice_req_valid=1 with idx's instr/operands, all stable until handshake (valid&ready). On the handshake cycle, sample the same-cycle response:
    - If nice_rsp_1cyc_err=1, or nice_rsp_1cyc_type=0, or dat_1[0]=0: status=01, go to FIN.
    - Else if idx=5, go to START; otherwise idx+1.
    - ready low: hold (no timeout in CFG).
  - START: nice_req_valid=1 with the start instruction. On handshake, clear the counter and go to WAIT_RSP. 1cyc inputs are ignored in this state.
  - WAIT_RSP: nice_rsp_multicyc_ready=1; counter increments each cycle.
    - On multicyc valid&ready: status = multicyc_err ? 10 : 00, go to FIN.
    - If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 with no valid: status=11, go to FIN.
    - Valid on the same cycle as the timeout: the response wins.
  - FIN: done=1 for one cycle, then IDLE.
- busy=1 in CFG, START, WAIT_RSP, FIN.
- A multicyc_valid arriving outside WAIT_RSP is not acknowledged (ready stays 0); it is consumed in WAIT_RSP.
- Handshake latency: minimum of one cycle per instruction, so best case from accept to done is 1+6+1+1(rsp)+1 cycles.

Decomposition:
- Shared package nice_gemm_pkg: OPCODE constant, funct7 constants (F7_CFG0..F7_CFG5, F7_START), status codes, FSM state enum.
- One natural sub-module, nice_cfg_mux: combinational idx → {funct7, rs1, rs2} select from the registered descriptor.
- FSM and counter live in the top.

Test Plan:
- Nominal job (lhs_cols=16, lhs_rows=8, rhs_cols=4, others distinct): req_ready tied high, dat_1=1 → seven consecutive handshakes with funct7 01,02,04,08,10,20,40 and instr[6:0]=0101011; multicyc_valid 20 cycles later → done pulse, status=00.
- Backpressure: req_ready low 3 cycles at idx 2 → instr/rs1/rs2 held (rs1=lhs_addr) with valid high, idx not advanced.
- Config rejection: 1cyc_err=1 on idx 3 handshake → done after next cycle, status=01, start funct7 never issued.
- Completion error: multicyc_err=1 with valid → status=10; next job accepted the cycle after done.
- Timeout: TIMEOUT_CYC=10, no multicyc_valid → done exactly 10 cycles after the start handshake, status=11; a late valid is not acked until the next job.
- Reset mid-CFG at idx 4 → nice_req_valid=0 and job_ready=1 after the edge, no done pulse.
